// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder: PortOut register, synchronised/filtered PortIn, change-capture FIFO.
// Optional input debounce filter enabled with `define PORT_DEBOUNCE_EN.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0400,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        DataAvail
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    s1, s2, filt, prev;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count, countNext;
  logic          ovf;
  logic          empty, full;
  logic [1:0]    offset;
  logic          rdHit, doPop, doPush, change, ovfSet, ovfClr;
  logic [31:0]   countWide;
  logic [2:0]    count3;
  logic          unusedBits;

  assign Hit       = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset    = Address[3:2];
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign rdHit     = MemRead & Hit;
  assign change    = (filt != prev);
  assign doPop     = rdHit && (offset == 2'd3) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign doPush    = change && (!full || doPop);
  assign ovfSet    = change && full && !doPop;
  assign ovfClr    = rdHit && (offset == 2'd2);
  assign countWide = 32'(count);
  assign count3    = (countWide > 32'd7) ? 3'd7 : countWide[2:0];
  assign unusedBits = ^{Address[1:0], (DEBOUNCE_CYCLES != 0)};

  always_comb begin
    countNext = count;
    if (doPush && !doPop)      countNext = count + 1'b1;
    else if (doPop && !doPush) countNext = count - 1'b1;
  end

  always_comb begin
    ReadData = '0;
    if (Hit) begin
      case (offset)
        2'd0:    ReadData = PortOut;
        2'd1:    ReadData = {24'b0, filt};
        2'd2:    ReadData = {25'b0, count3, 1'b0, ovf, full, !empty};
        default: ReadData = empty ? '0 : {24'b0, mem[rdPtr]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= filt;
    end
  end

`ifdef PORT_DEBOUNCE_EN
  logic [7:0]                         cand;
  logic [$clog2(DEBOUNCE_CYCLES+1):0] dbCnt;

  // filt follows s2 only after DEBOUNCE_CYCLES consecutive edges on the same candidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand  <= '0;
      dbCnt <= '0;
      filt  <= '0;
    end else if (s2 != cand) begin
      cand  <= s2;
      dbCnt <= '0;
    end else if (32'(dbCnt) == DEBOUNCE_CYCLES - 1) begin
      filt  <= cand;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) filt <= '0;
    else       filt <= s2;
  end
`endif

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= filt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      DataAvail <= 1'b0;
    end else begin
      if (MemWrite && Hit && (offset == 2'd0)) PortOut <= WriteData;
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count     <= countNext;
      DataAvail <= (countNext != '0);
      if (ovfSet)      ovf <= 1'b1;
      else if (ovfClr) ovf <= 1'b0;
    end
  end

endmodule
